// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arbiter_pkg;

  // Arbiter FSM states: IDLE arbitrates every cycle, BURST keeps the RAM for m1.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // Master identifiers, also used to remember the last granted master.
  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_t;

  // Access direction encoding of the *_we inputs.
  localparam logic ACC_RD = 1'b0;
  localparam logic ACC_WR = 1'b1;

  // True when a write-enable value encodes a read access.
  function automatic logic is_read(input logic we);
    return (we == ACC_RD);
  endfunction

  // True when a write-enable value encodes a write access.
  function automatic logic is_write(input logic we);
    return (we == ACC_WR);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-requester round-robin picker: on a tie the master that was not granted
// last time wins; a single request is always granted.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  master_t    last,
  output logic [1:0] gnt
);

  // Pick at most one requester, alternating on ties.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) begin
      if (last == M0) begin
        gnt = 2'b10;
      end else begin
        gnt = 2'b01;
      end
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data RAM arbiter between the core load/store port (m0) and a DMA/loader port
// (m1). m0 issues single beats; m1 may hold the RAM for a burst of m1_len+1
// beats. Grants are combinational in the request cycle, read data returns one
// cycle later and is routed to whichever master issued the read.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [AW-1:0]     m0_addr,
  input  logic [DW-1:0]     m0_wdata,
  input  logic [DW/8-1:0]   m0_be,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DW-1:0]     m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [AW-1:0]     m1_addr,
  input  logic [DW-1:0]     m1_wdata,
  input  logic [DW/8-1:0]   m1_be,
  input  logic [LEN_W-1:0]  m1_len,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DW-1:0]     m1_rdata,

  output logic              core_stall,

  output logic              ram_en,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_wdata,
  output logic [DW/8-1:0]   ram_be,
  input  logic [DW-1:0]     ram_rdata
);

  arb_state_t       state;
  logic [LEN_W-1:0] beat_cnt;
  master_t          last_gnt;
  logic [1:0]       pick;

  rr_pick2 u_pick (
    .req  ({m1_req, m0_req}),
    .last (last_gnt),
    .gnt  (pick)
  );

  // Grant decode: round-robin in IDLE, m1 owns the RAM in BURST. Grants are
  // forced low while reset is held so no RAM access leaks out of reset.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (state == ST_IDLE) begin
        m0_gnt = pick[0];
        m1_gnt = pick[1];
      end else begin
        m1_gnt = m1_req;
      end
    end
  end

  assign core_stall = m0_req & ~m0_gnt;

  // RAM port mux: forward the granted master's fields, drive zeros when idle.
  always_comb begin
    ram_en    = m0_gnt | m1_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_be    = '0;
    if (m1_gnt) begin
      ram_we    = is_write(m1_we);
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_be    = m1_be;
    end else if (m0_gnt) begin
      ram_we    = is_write(m0_we);
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
      ram_be    = m0_be;
    end
  end

  // Arbitration FSM: tracks the last winner and counts the remaining m1 burst
  // beats. The counter is loaded with m1_len on the first beat and the beat
  // seen with a count of one is the last, so it never wraps below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      last_gnt <= M1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m1_gnt) begin
            last_gnt <= M1;
            if (m1_len != '0) begin
              beat_cnt <= m1_len;
              state    <= ST_BURST;
            end
          end else if (m0_gnt) begin
            last_gnt <= M0;
          end
        end
        ST_BURST: begin
          if (!m1_req) begin
            beat_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            beat_cnt <= beat_cnt - LEN_W'(1);
            if (beat_cnt == LEN_W'(1)) begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          beat_cnt <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-owner tracking: remember which master issued a read so the RAM's
  // one-cycle-late data goes back to it; writes never produce a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt & is_read(m0_we);
      m1_rvalid <= m1_gnt & is_read(m1_we);
    end
  end

  assign m0_rdata = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata = m1_rvalid ? ram_rdata : '0;

endmodule
